banked_data_mem_xbar: RTL and testbench

- Multi-port, multi-bank data scratchpad: NUM_PORTS OBI-style requesters reach NUM_BANKS single-port SRAM banks through a crossbar.
- Word-interleaved address map; per-bank round-robin arbitration; fixed 1-cycle response latency.
- Out-of-range error responses and a saturating bank-conflict counter.
- Sits between the core's LSU ports and the physical SRAM macros, replacing the one-requester-per-bank data memory.

---
 rtl/banked_data_mem_xbar_if.sv | 27 ++
 rtl/banked_data_mem_xbar.sv | 149 ++++++++++++++
 tb/tb_banked_data_mem_xbar.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/banked_data_mem_xbar_if.sv
// Request/response bus between NUM_PORTS OBI-style requesters and the banked
// data scratchpad crossbar. Signals are flattened per port, port 0 in the LSBs.
interface banked_data_mem_xbar_if #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32
);
  logic [NUM_PORTS-1:0]          req_i;
  logic [NUM_PORTS-1:0]          we_i;
  logic [NUM_PORTS*DATA_W/8-1:0] be_i;
  logic [NUM_PORTS*ADDR_W-1:0]   addr_i;
  logic [NUM_PORTS*DATA_W-1:0]   wdata_i;
  logic [NUM_PORTS-1:0]          gnt_o;
  logic [NUM_PORTS-1:0]          rvalid_o;
  logic [NUM_PORTS*DATA_W-1:0]   rdata_o;
  logic [NUM_PORTS-1:0]          err_o;

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/banked_data_mem_xbar.sv
// Multi-port, word-interleaved banked scratchpad: per-bank round-robin crossbar,
// single-cycle responses, out-of-range error replies and a saturating conflict counter.
module banked_data_mem_xbar #(
  parameter int unsigned DATA_MEM_SIZE_BYTE = 131072,
  parameter int unsigned DATA_MEM_NUM_BANKS = 4,
  parameter int unsigned NUM_PORTS          = 4,
  parameter int unsigned DATA_W             = 32,
  parameter int unsigned ADDR_W             = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  banked_data_mem_xbar_if.slave bus,
  output logic [31:0]           conflict_cnt_o
);
  localparam int unsigned NB     = DATA_MEM_NUM_BANKS;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(BE_W);
  localparam int unsigned NB_LOG = $clog2(NB);
  localparam int unsigned BANK_W = (NB > 1) ? NB_LOG : 1;
  localparam int unsigned DEPTH  = DATA_MEM_SIZE_BYTE / (NB * BE_W);
  localparam int unsigned ROW_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0] port_req, port_we, in_range, gnt;
  logic [BE_W-1:0]      port_be    [NUM_PORTS];
  logic [DATA_W-1:0]    port_wdata [NUM_PORTS];
  logic [BANK_W-1:0]    port_bank  [NUM_PORTS];
  logic [ROW_W-1:0]     port_row   [NUM_PORTS];

  logic [NB-1:0]        bank_vld, bank_we;
  logic [BE_W-1:0]      bank_be    [NB];
  logic [DATA_W-1:0]    bank_wdata [NB];
  logic [ROW_W-1:0]     bank_row   [NB];
  logic [PORT_W-1:0]    rr_d [NB], rr_q [NB];

  logic [NUM_PORTS-1:0] rvalid_d, rvalid_q, err_d, err_q, rd_d, rd_q;
  logic [BANK_W-1:0]    rbank_d [NUM_PORTS], rbank_q [NUM_PORTS];
  logic [31:0]          conflict_d, conflict_q;

  logic [DATA_W-1:0]    sram [NB][DEPTH];
  logic [DATA_W-1:0]    sram_rdata [NB];
  logic [NUM_PORTS*DATA_W-1:0] rdata;

  always_comb begin
    port_req = bus.req_i;
    port_we  = bus.we_i;
    in_range = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_be[p]    = bus.be_i[p*BE_W +: BE_W];
      port_wdata[p] = bus.wdata_i[p*DATA_W +: DATA_W];
      port_bank[p]  = BANK_W'((bus.addr_i[p*ADDR_W +: ADDR_W] >> OFF_W) & ADDR_W'(NB - 1));
      port_row[p]   = ROW_W'(bus.addr_i[p*ADDR_W +: ADDR_W] >> (OFF_W + NB_LOG));
      in_range[p]   = 64'(bus.addr_i[p*ADDR_W +: ADDR_W]) < 64'(DATA_MEM_SIZE_BYTE);
    end
  end

  // Out-of-range requests bypass arbitration; each bank scans ports upward from rr.
  always_comb begin
    int unsigned       cand;
    logic [PORT_W-1:0] pidx;
    cand     = 0;
    pidx     = '0;
    gnt      = port_req & ~in_range;
    bank_vld = '0;
    bank_we  = '0;
    for (int b = 0; b < NB; b++) begin
      bank_be[b]    = '0;
      bank_wdata[b] = '0;
      bank_row[b]   = '0;
      rr_d[b]       = rr_q[b];
      for (int k = 0; k < NUM_PORTS; k++) begin
        cand = 32'(rr_q[b]) + 32'(k);
        if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
        pidx = PORT_W'(cand);
        if (!bank_vld[b] && port_req[pidx] && in_range[pidx] &&
            port_bank[pidx] == BANK_W'(b)) begin
          bank_vld[b]   = 1'b1;
          bank_we[b]    = port_we[pidx];
          bank_be[b]    = port_be[pidx];
          bank_wdata[b] = port_wdata[pidx];
          bank_row[b]   = port_row[pidx];
          gnt[pidx]     = 1'b1;
          rr_d[b]       = (cand + 1 >= NUM_PORTS) ? '0 : PORT_W'(cand + 1);
        end
      end
    end
  end

  // The 33-bit sum catches overflow so the counter pins at all-ones.
  always_comb begin
    logic [32:0] sum;
    sum      = {1'b0, conflict_q};
    rvalid_d = gnt;
    err_d    = gnt & ~in_range;
    rd_d     = gnt & in_range & ~port_we;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rbank_d[p] = port_bank[p];
      if (port_req[p] && !gnt[p]) sum = sum + 33'd1;
    end
    conflict_d = sum[32] ? '1 : sum[31:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q   <= '0;
      err_q      <= '0;
      rd_q       <= '0;
      conflict_q <= '0;
      for (int p = 0; p < NUM_PORTS; p++) rbank_q[p] <= '0;
      for (int b = 0; b < NB; b++) rr_q[b] <= '0;
    end else begin
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      rd_q       <= rd_d;
      conflict_q <= conflict_d;
      for (int p = 0; p < NUM_PORTS; p++) rbank_q[p] <= rbank_d[p];
      for (int b = 0; b < NB; b++) rr_q[b] <= rr_d[b];
    end
  end

  // SRAM macros model: contents and read registers are deliberately not reset.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NB; b++) begin
      if (bank_vld[b]) begin
        if (bank_we[b]) begin
          for (int i = 0; i < BE_W; i++) begin
            if (bank_be[b][i]) sram[b][bank_row[b]][i*8 +: 8] <= bank_wdata[b][i*8 +: 8];
          end
        end else begin
          sram_rdata[b] <= sram[b][bank_row[b]];
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rd_q[p]) rdata[p*DATA_W +: DATA_W] = sram_rdata[rbank_q[p]];
    end
  end

  assign bus.gnt_o      = gnt;
  assign bus.rvalid_o   = rvalid_q;
  assign bus.err_o      = err_q;
  assign bus.rdata_o    = rdata;
  assign conflict_cnt_o = conflict_q;

endmodule

// File: tb/tb_banked_data_mem_xbar.sv
// Scoreboard bench for banked_data_mem_xbar: grants observed on the bus push
// expected responses computed from a reference memory model.
module tb_banked_data_mem_xbar;
  localparam int NP       = 4;
  localparam int DW       = 32;
  localparam int AW       = 32;
  localparam int MEM_SIZE = 131072;

  logic        clk  = 1'b0;
  logic        rstN = 1'b0;
  logic [31:0] conflictCnt;

  banked_data_mem_xbar_if #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW)) bus ();

  banked_data_mem_xbar #(
    .DATA_MEM_SIZE_BYTE(MEM_SIZE),
    .DATA_MEM_NUM_BANKS(4),
    .NUM_PORTS(NP),
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk_i(clk),
    .rst_ni(rstN),
    .bus(bus),
    .conflict_cnt_o(conflictCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic        err;
    logic        chk;
    logic [31:0] data;
  } expT;

  expT         scoreboard[$];
  logic [31:0] modelMem [int];
  int          checks = 0;
  int          errors = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] getRdata(input int p);
    return bus.rdata_o[p*DW +: DW];
  endfunction

  task automatic clearAll();
    bus.req_i   = '0;
    bus.we_i    = '0;
    bus.be_i    = '0;
    bus.addr_i  = '0;
    bus.wdata_i = '0;
  endtask

  task automatic applyStimulus(input int p, input logic we, input logic [3:0] be,
                               input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_i[p]           = 1'b1;
    bus.we_i[p]            = we;
    bus.be_i[p*4 +: 4]     = be;
    bus.addr_i[p*AW +: AW] = addr;
    bus.wdata_i[p*DW +: DW] = wdata;
  endtask

  // Reference model: applies a granted transaction and queues its expected response.
  task automatic modelGrant(input int p);
    expT         e;
    logic [31:0] a, w, word;
    logic [3:0]  be;
    int          key;
    a      = bus.addr_i[p*AW +: AW];
    w      = bus.wdata_i[p*DW +: DW];
    be     = bus.be_i[p*4 +: 4];
    e.port = p;
    e.err  = 1'b0;
    e.chk  = 1'b1;
    e.data = '0;
    if (a >= 32'(MEM_SIZE)) begin
      e.err = 1'b1;
    end else begin
      key = int'(a >> 2);
      if (bus.we_i[p]) begin
        if (modelMem.exists(key) || be == 4'hF) begin
          word = modelMem.exists(key) ? modelMem[key] : 32'h0;
          for (int i = 0; i < 4; i++) if (be[i]) word[i*8 +: 8] = w[i*8 +: 8];
          modelMem[key] = word;
        end
      end else if (modelMem.exists(key)) begin
        e.data = modelMem[key];
      end else begin
        e.chk = 1'b0;
      end
    end
    scoreboard.push_back(e);
  endtask

  // Every falling edge: retire last cycle's grants, then record this cycle's grants.
  always @(negedge clk) begin
    logic [NP-1:0] pend;
    expT           e;
    if (!rstN) begin
      checkOutput("rvalid_in_reset", 64'(bus.rvalid_o), 64'h0);
      scoreboard.delete();
    end else begin
      pend = '0;
      foreach (scoreboard[i]) pend[scoreboard[i].port] = 1'b1;
      checkOutput("rvalid", 64'(bus.rvalid_o), 64'(pend));
      while (scoreboard.size() > 0) begin
        e = scoreboard.pop_front();
        checkOutput($sformatf("err_p%0d", e.port), 64'(bus.err_o[e.port]), 64'(e.err));
        if (e.chk) checkOutput($sformatf("rdata_p%0d", e.port), 64'(getRdata(e.port)), 64'(e.data));
      end
      for (int p = 0; p < NP; p++) if (bus.gnt_o[p]) modelGrant(p);
    end
  end

  // All four ports hold reads to one bank; round-robin must serve 0,1,2,3.
  task automatic holdAll(input logic [31:0] a);
    logic [NP-1:0] seen;
    for (int p = 0; p < NP; p++) applyStimulus(p, 1'b0, 4'hF, a, 32'h0);
    for (int k = 0; k < NP; k++) begin
      @(negedge clk);
      seen = bus.gnt_o;
      checkOutput($sformatf("rr_gnt_c%0d", k), 64'(seen), 64'(4'b0001 << k));
      @(posedge clk); #1;
      bus.req_i = bus.req_i & ~seen;
    end
    clearAll();
    @(negedge clk);
    checkOutput("rr_conflict_cnt", 64'(conflictCnt), 64'd6);
  endtask

  initial begin
    clearAll();
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_rvalid", 64'(bus.rvalid_o), 64'h0);
    checkOutput("reset_err", 64'(bus.err_o), 64'h0);
    checkOutput("reset_conflict", 64'(conflictCnt), 64'h0);
    for (int p = 0; p < NP; p++) checkOutput($sformatf("reset_rdata_p%0d", p), 64'(getRdata(p)), 64'h0);
    @(posedge clk); #1;
    rstN = 1'b1;

    for (int i = 0; i < 32; i++) begin
      applyStimulus(0, 1'b1, 4'hF, 32'(i * 4), 32'hA500_0000 | 32'(i * 32'h111));
      @(negedge clk);
      checkOutput("setup_gnt", 64'(bus.gnt_o), 64'h1);
      @(posedge clk); #1;
      clearAll();
    end

    $display("[TB] write then read back");
    applyStimulus(0, 1'b1, 4'hF, 32'h0, 32'hDEAD_BEEF);
    @(negedge clk); checkOutput("t1_wr_gnt", 64'(bus.gnt_o), 64'h1);
    @(posedge clk); #1; clearAll();
    applyStimulus(0, 1'b0, 4'hF, 32'h0, 32'h0);
    @(negedge clk); checkOutput("t1_rd_gnt", 64'(bus.gnt_o), 64'h1);
    @(posedge clk); #1; clearAll();
    @(negedge clk);
    checkOutput("t1_rvalid", 64'(bus.rvalid_o[0]), 64'h1);
    checkOutput("t1_rdata", 64'(getRdata(0)), 64'hDEAD_BEEF);

    $display("[TB] four banks in parallel");
    for (int p = 0; p < NP; p++) applyStimulus(p, 1'b0, 4'hF, 32'(p * 4), 32'h0);
    @(negedge clk); checkOutput("t2_gnt", 64'(bus.gnt_o), 64'hF);
    @(posedge clk); #1; clearAll();
    @(negedge clk);
    checkOutput("t2_rvalid", 64'(bus.rvalid_o), 64'hF);
    checkOutput("t2_rdata_p3", 64'(getRdata(3)), 64'hA500_0333);
    checkOutput("t2_conflict", 64'(conflictCnt), 64'h0);

    @(posedge clk); #1; rstN = 1'b0;
    @(negedge clk); checkOutput("pulse_conflict", 64'(conflictCnt), 64'h0);
    @(posedge clk); #1; rstN = 1'b1;

    $display("[TB] same-bank round robin");
    holdAll(32'h10);

    $display("[TB] out-of-range access");
    @(posedge clk); #1;
    applyStimulus(2, 1'b1, 4'hF, 32'h0002_0000, 32'hFFFF_FFFF);
    @(negedge clk); checkOutput("t4_wr_gnt", 64'(bus.gnt_o), 64'h4);
    @(posedge clk); #1; clearAll();
    applyStimulus(2, 1'b0, 4'hF, 32'h0002_0000, 32'h0);
    @(negedge clk); checkOutput("t4_rd_gnt", 64'(bus.gnt_o), 64'h4);
    @(posedge clk); #1; clearAll();
    @(negedge clk);
    checkOutput("t4_err", 64'(bus.err_o[2]), 64'h1);
    checkOutput("t4_rdata", 64'(getRdata(2)), 64'h0);
    @(posedge clk); #1;
    for (int p = 0; p < NP; p++) applyStimulus(p, 1'b0, 4'hF, 32'(p * 4), 32'h0);
    @(negedge clk);
    @(posedge clk); #1; clearAll();
    @(negedge clk);
    checkOutput("t4_bank0_intact", 64'(getRdata(0)), 64'hDEAD_BEEF);

    $display("[TB] byte enables");
    @(posedge clk); #1;
    applyStimulus(1, 1'b1, 4'hF, 32'h40, 32'h1122_3344);
    @(posedge clk); #1; clearAll();
    applyStimulus(1, 1'b1, 4'b0101, 32'h40, 32'hAABB_CCDD);
    @(posedge clk); #1; clearAll();
    applyStimulus(1, 1'b0, 4'hF, 32'h40, 32'h0);
    @(posedge clk); #1; clearAll();
    @(negedge clk); checkOutput("t5_merge", 64'(getRdata(1)), 64'h11BB_33DD);
    @(posedge clk); #1;
    applyStimulus(3, 1'b1, 4'h0, 32'h40, 32'hFFFF_FFFF);
    @(posedge clk); #1; clearAll();
    applyStimulus(3, 1'b0, 4'hF, 32'h40, 32'h0);
    @(posedge clk); #1; clearAll();
    @(negedge clk); checkOutput("t5_be0_nochange", 64'(getRdata(3)), 64'h11BB_33DD);

    $display("[TB] reset during response");
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, 4'hF, 32'h0, 32'h0);
    @(negedge clk); checkOutput("t6_gnt", 64'(bus.gnt_o), 64'h1);
    @(posedge clk); #1; clearAll(); rstN = 1'b0;
    @(negedge clk);
    checkOutput("t6_rvalid", 64'(bus.rvalid_o), 64'h0);
    checkOutput("t6_rdata", 64'(getRdata(0)), 64'h0);
    checkOutput("t6_conflict", 64'(conflictCnt), 64'h0);
    @(posedge clk); #1; rstN = 1'b1;
    holdAll(32'h10);

    @(posedge clk); #1; clearAll();
    repeat (2) @(negedge clk);
    checkOutput("sb_drain", 64'(scoreboard.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
